// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit adder/subtractor with condition flags, one SEG-bit carry segment per stage.
// Define ADDSUB_PIPE_SAT_EN to replace overflowing results with the signed saturation value.
module addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             CF,
  output logic             OF,
  output logic             SF,
  output logic             ZF
);

  localparam int STAGES = WIDTH / SEG;
  localparam int MSB    = WIDTH - 1;
  localparam int LAST   = STAGES - 1;
  localparam int NREG   = (STAGES > 1) ? STAGES - 1 : 1;

  generate
    if ((WIDTH % SEG) != 0 || WIDTH < 2) begin : g_param_check
      $error("addsub_pipe: WIDTH must be >= 2 and a multiple of SEG");
    end
  endgenerate

  // Registers between stages; entry k holds the state leaving stage k.
  logic             sv   [NREG];
  logic             ssub [NREG];
  logic             sc   [NREG];
  logic [WIDTH-1:0] sx   [NREG];
  logic [WIDTH-1:0] sy   [NREG];
  logic [WIDTH-1:0] sr   [NREG];

  // Values entering each stage, and what each stage produces.
  logic             av   [STAGES];
  logic             asub [STAGES];
  logic             ac   [STAGES];
  logic [WIDTH-1:0] ax   [STAGES];
  logic [WIDTH-1:0] ay   [STAGES];
  logic [WIDTH-1:0] ar   [STAGES];
  logic [WIDTH-1:0] nr   [STAGES];
  logic             nc   [STAGES];
  logic [SEG:0]     segsum [STAGES];

  logic [WIDTH-1:0] ff;
  logic             rawof;

  assign in_ready = !out_valid || out_ready;

  always_comb begin
    av[0]   = in_valid && in_ready;
    asub[0] = sub;
    ac[0]   = sub;
    ax[0]   = x;
    ay[0]   = y ^ {WIDTH{sub}};
    ar[0]   = '0;
    for (int k = 1; k < STAGES; k++) begin
      av[k]   = sv[k-1];
      asub[k] = ssub[k-1];
      ac[k]   = sc[k-1];
      ax[k]   = sx[k-1];
      ay[k]   = sy[k-1];
      ar[k]   = sr[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      segsum[k] = {1'b0, ax[k][k*SEG +: SEG]} + {1'b0, ay[k][k*SEG +: SEG]}
                + {{SEG{1'b0}}, ac[k]};
      nr[k] = ar[k];
      nr[k][k*SEG +: SEG] = segsum[k][SEG-1:0];
      nc[k] = segsum[k][SEG];
    end
    rawof = (ax[LAST][MSB] == ay[LAST][MSB]) && (nr[LAST][MSB] != ax[LAST][MSB]);
`ifdef ADDSUB_PIPE_SAT_EN
    // Overflow direction follows the sign of operand A.
    if (rawof)
      ff = ax[LAST][MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      ff = nr[LAST];
`else
    ff = nr[LAST];
`endif
  end

  // Single global enable: a stalled output freezes every stage, bubbles included.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) begin
        sv[k]   <= 1'b0;
        ssub[k] <= 1'b0;
        sc[k]   <= 1'b0;
        sx[k]   <= '0;
        sy[k]   <= '0;
        sr[k]   <= '0;
      end
      out_valid <= 1'b0;
      f         <= '0;
      cout      <= 1'b0;
      CF        <= 1'b0;
      OF        <= 1'b0;
      SF        <= 1'b0;
      ZF        <= 1'b0;
    end else if (in_ready) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        sv[k]   <= av[k];
        ssub[k] <= asub[k];
        sc[k]   <= nc[k];
        sx[k]   <= ax[k];
        sy[k]   <= ay[k];
        sr[k]   <= nr[k];
      end
      out_valid <= av[LAST];
      f         <= ff;
      cout      <= nc[LAST];
      CF        <= nc[LAST] ^ asub[LAST];
      OF        <= rawof;
      SF        <= ff[MSB];
      ZF        <= (ff == '0);
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe (WIDTH=32, SEG=8): directed flag vectors, random
// back-to-back traffic with output stalls against an arithmetic model, and mid-flight reset.
module tb_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic [31:0] y;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] f;
  logic        cout, CF, OF, SF, ZF;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [36:0] e;
  } vec_t;

  addsub_pipe #(.WIDTH(32), .SEG(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .f(f), .cout(cout), .CF(CF), .OF(OF), .SF(SF), .ZF(ZF)
  );

  always #5 clk = ~clk;

  function automatic logic [36:0] observed();
    return {f, cout, CF, OF, SF, ZF};
  endfunction

  // Reference: unsigned/signed arithmetic on 64-bit integers.
  function automatic logic [36:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint unsigned ua = {32'h0, a};
    longint unsigned ub = {32'h0, b};
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint sres;
    logic [31:0] r;
    logic c, o;
    if (!s) begin
      r = a + b;
      c = (ua + ub) > 64'h0000_0000_FFFF_FFFF;
      sres = sa + sb;
    end else begin
      r = a - b;
      c = (ua >= ub);
      sres = sa - sb;
    end
    o = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
`ifdef ADDSUB_PIPE_SAT_EN
    if (o) r = (sres > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    return {r, c, c ^ s, o, r[31], (r == 32'h0)};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0; sub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (observed() !== 37'h0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got valid=%b f/flags=%h, expected valid=0 f/flags=0", out_valid, observed());
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_ready: got %b, expected 1", in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    vec_t v[$];
    int lat;
    v.push_back('{32'h7FFF_FFFF, 32'h8000_0002, 1'b0, {32'h0000_0001, 5'b11000}});
`ifdef ADDSUB_PIPE_SAT_EN
    v.push_back('{32'h7FFF_FFFF, 32'h8000_0002, 1'b1, {32'h7FFF_FFFF, 5'b01100}});
`else
    v.push_back('{32'h7FFF_FFFF, 32'h8000_0002, 1'b1, {32'hFFFF_FFFD, 5'b01110}});
`endif
    v.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {32'h0000_0000, 5'b11001}});
    v.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, {32'hFFFF_FFFE, 5'b10010}});
`ifdef ADDSUB_PIPE_SAT_EN
    v.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, {32'h8000_0000, 5'b11110}});
`else
    v.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, {32'h0000_0000, 5'b11101}});
`endif
    v.push_back('{32'h8000_0000, 32'h8000_0000, 1'b1, {32'h0000_0000, 5'b10001}});
`ifdef ADDSUB_PIPE_SAT_EN
    v.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {32'h7FFF_FFFF, 5'b00100}});
    v.push_back('{32'h8000_0000, 32'h0000_0001, 1'b1, {32'h8000_0000, 5'b10110}});
`endif
    foreach (v[i]) begin
      @(negedge clk);
      x = v[i].a; y = v[i].b; sub = v[i].s; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      tests_run++;
      if (lat != 3) begin
        tests_failed++;
        $display("[TB] FAIL latency_%0d: got %0d cycles, expected 3", i, lat);
      end
      tests_run++;
      if (observed() !== v[i].e) begin
        tests_failed++;
        $display("[TB] FAIL vector_%0d: got f/flags=%h, expected %h", i, observed(), v[i].e);
      end
    end
    @(negedge clk);
  endtask

  // Random traffic with stalls: results are predicted at accept time and consumed in order.
  task automatic test_back_to_back();
    logic [36:0] q[$];
    logic [36:0] held;
    logic [36:0] exp_v;
    logic held_valid = 1'b0;
    int accepted = 0;
    int cyc = 0;
    while ((accepted < 24 || q.size() > 0) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (held_valid) begin
        tests_run++;
        if (out_valid !== 1'b1 || observed() !== held) begin
          tests_failed++;
          $display("[TB] FAIL stall_hold: got valid=%b f/flags=%h, expected valid=1 %h", out_valid, observed(), held);
        end
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (accepted < 24) begin
        in_valid = ($urandom_range(0, 3) != 0);
        x = pick(); y = pick(); sub = $urandom_range(0, 1);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      tests_run++;
      if (in_ready !== (!out_valid || out_ready)) begin
        tests_failed++;
        $display("[TB] FAIL in_ready: got %b, expected %b", in_ready, (!out_valid || out_ready));
      end
      if (out_valid && out_ready) begin
        tests_run++;
        if (q.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL extra_output: got f/flags=%h, expected no output", observed());
        end else begin
          exp_v = q.pop_front();
          if (observed() !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL stream_result: got f/flags=%h, expected %h", observed(), exp_v);
          end
        end
      end
      held_valid = out_valid && !out_ready;
      held = observed();
      if (in_valid && in_ready) begin
        q.push_back(model(x, y, sub));
        accepted++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    tests_run++;
    if (cyc >= 2000 || q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL stream_drain: got %0d pending after %0d cycles, expected 0", q.size(), cyc);
    end
  endtask

  task automatic test_reset_midflight();
    repeat (5) @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      x = $urandom; y = $urandom; sub = i[0]; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_flush: got valid=%b ready=%b, expected valid=0 ready=1", out_valid, in_ready);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL reset_no_emerge_%0d: got valid=%b, expected 0", i, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
